// File: rtl/moore_pkg.sv
// Shared types and constants for the Moore-style word serializer.
package moore_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/moore_serializer.sv
// Parallel-to-serial front end: valid/ready word in, MSB-first registered bit stream out.
// Define MOORE_SER_PARITY_EN to append an even-parity bit after each word.
module moore_serializer
    import moore_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             ob_n;
    logic             last_bit;
    logic             accept;
`ifdef MOORE_SER_PARITY_EN
    logic             par, par_n;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sreg_n   = sreg;
`ifdef MOORE_SER_PARITY_EN
        par_n    = par;
`endif
        last_bit = (state == SHIFT) && (cnt == '0);
`ifdef MOORE_SER_PARITY_EN
        load_ready = (state == IDLE) || (state == PARITY);
`else
        load_ready = (state == IDLE) || last_bit;
`endif
        accept   = load_valid && load_ready;

        case (state)
            SHIFT: begin
                sreg_n = sreg << 1;
                if (!last_bit)
                    cnt_n = cnt - 1'b1;
                else
`ifdef MOORE_SER_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = IDLE;
`endif
            end
`ifdef MOORE_SER_PARITY_EN
            PARITY:  state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase

        // An accept can only happen where load_ready allows it, so it overrides any state.
        if (accept) begin
            state_n = SHIFT;
            cnt_n   = CW'(WIDTH - 1);
            sreg_n  = load_data;
`ifdef MOORE_SER_PARITY_EN
            par_n   = ^load_data;
`endif
        end

        case (state_n)
            SHIFT:   ob_n = sreg_n[WIDTH-1];
`ifdef MOORE_SER_PARITY_EN
            PARITY:  ob_n = par_n;
`endif
            default: ob_n = 1'b0;
        endcase
    end

    // Outputs are flopped from next-state values so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef MOORE_SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sreg      <= sreg_n;
            out_bit   <= ob_n;
            out_valid <= (state_n != IDLE);
            busy      <= (state_n != IDLE);
`ifdef MOORE_SER_PARITY_EN
            par       <= par_n;
`endif
        end
    end

endmodule
